// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter
//
// Shares the single AXI-style transaction port of the DDR transaction
// controller between two requesters (for example a DMA engine and a CPU
// bridge). One whole transaction is granted at a time: the address, every data
// beat and, for writes, the response. Masters are served round-robin. The
// arbiter runs entirely in the core_clk domain.
//
// Parameters
//   ADDR_W  byte address width
//   DATA_W  data beat width
//
// Ports
//   core_clk, core_rst            clock; asynchronous active-high reset
//   mN_aw* / mN_w* / mN_b*        write address, data and response of master N
//   mN_ar* / mN_r*                read address and data of master N
//   s_aw* / s_w* / s_b*           write channels towards the DDR controller
//   s_ar* / s_r*                  read channels towards the DDR controller
//   grant                         one-hot owner of s_*, 00 when idle
//   busy                          high whenever a transaction is in progress
//
// All handshake forwarding is combinational through muxes selected by the
// registered state and grant, so a granted master sustains one beat per cycle.
module ddr_axi_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
) (
  input  logic              core_clk,
  input  logic              core_rst,

  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [7:0]        m0_awlen,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic              m0_wlast,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic              m0_rlast,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic              m1_wlast,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic              m1_rlast,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [7:0]        s_awlen,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic              s_wlast,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic              s_rlast,
  input  logic [DATA_W-1:0] s_rdata,

  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] grant_q, grant_nxt;
  logic       last_q, last_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [7:0] len_q, len_nxt;

  // Master inputs gathered into index-able vectors so the granted master can
  // be selected with a single index.
  logic [1:0]             m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic [1:0][ADDR_W-1:0] m_awaddr, m_araddr;
  logic [1:0][7:0]        m_awlen, m_arlen;
  logic [1:0][DATA_W-1:0] m_wdata;

  logic [1:0]             m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast;
  logic [1:0][DATA_W-1:0] m_rdata;

  assign m_awvalid = {m1_awvalid, m0_awvalid};
  assign m_wvalid  = {m1_wvalid,  m0_wvalid};
  assign m_wlast   = {m1_wlast,   m0_wlast};
  assign m_bready  = {m1_bready,  m0_bready};
  assign m_arvalid = {m1_arvalid, m0_arvalid};
  assign m_rready  = {m1_rready,  m0_rready};
  assign m_awaddr  = {m1_awaddr,  m0_awaddr};
  assign m_araddr  = {m1_araddr,  m0_araddr};
  assign m_awlen   = {m1_awlen,   m0_awlen};
  assign m_arlen   = {m1_arlen,   m0_arlen};
  assign m_wdata   = {m1_wdata,   m0_wdata};

  assign {m1_awready, m0_awready} = m_awready;
  assign {m1_wready,  m0_wready}  = m_wready;
  assign {m1_bvalid,  m0_bvalid}  = m_bvalid;
  assign {m1_arready, m0_arready} = m_arready;
  assign {m1_rvalid,  m0_rvalid}  = m_rvalid;
  assign {m1_rlast,   m0_rlast}   = m_rlast;
  assign m0_rdata = m_rdata[0];
  assign m1_rdata = m_rdata[1];

  // grant is one-hot while owned, so its upper bit is the owner index.
  logic g;
  assign g = grant_q[1];

  logic [1:0] req;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs, last_beat;

  assign req       = m_awvalid | m_arvalid;
  assign aw_hs     = m_awvalid[g] & s_awready;
  assign w_hs      = m_wvalid[g] & s_wready;
  assign b_hs      = s_bvalid & m_bready[g];
  assign ar_hs     = m_arvalid[g] & s_arready;
  assign r_hs      = s_rvalid & m_rready[g];
  assign last_beat = (cnt_q == len_q);

  assign grant = grant_q;
  assign busy  = (state != IDLE);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
      len_q   <= len_nxt;
    end
  end

  logic pick;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    len_nxt   = len_q;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // Under contention the master that was not served last wins.
          if (req == 2'b11) pick = ~last_q;
          else              pick = req[1];
          grant_nxt = pick ? 2'b10 : 2'b01;
          last_nxt  = pick;
          // A master offering both a write and a read gets the write first.
          state_nxt = m_awvalid[pick] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (aw_hs) begin
          len_nxt   = m_awlen[g];
          cnt_nxt   = 8'd0;
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          cnt_nxt = cnt_q + 8'd1;
          if (m_wlast[g] || last_beat) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          len_nxt   = m_arlen[g];
          cnt_nxt   = 8'd0;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          cnt_nxt = cnt_q + 8'd1;
          if (s_rlast || last_beat) begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_comb begin
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    m_rlast   = 2'b00;
    m_rdata   = '0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awlen   = 8'd0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_wdata   = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arlen   = 8'd0;
    s_rready  = 1'b0;
    case (state)
      WR_ADDR: begin
        s_awvalid    = m_awvalid[g];
        s_awaddr     = m_awaddr[g];
        s_awlen      = m_awlen[g];
        m_awready[g] = s_awready;
      end
      WR_DATA: begin
        s_wvalid    = m_wvalid[g];
        s_wdata     = m_wdata[g];
        s_wlast     = m_wlast[g];
        m_wready[g] = s_wready;
      end
      WR_RESP: begin
        m_bvalid[g] = s_bvalid;
        s_bready    = m_bready[g];
      end
      RD_ADDR: begin
        s_arvalid    = m_arvalid[g];
        s_araddr     = m_araddr[g];
        s_arlen      = m_arlen[g];
        m_arready[g] = s_arready;
      end
      RD_DATA: begin
        m_rvalid[g] = s_rvalid;
        m_rdata[g]  = s_rdata;
        // The arbiter's own beat count closes the burst even if the
        // controller never flags its last beat.
        m_rlast[g]  = s_rlast | last_beat;
        s_rready    = m_rready[g];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/ddr_axi_arbiter.md
# ddr_axi_arbiter

Two-port arbiter that shares the single AXI-style transaction port of the DDR transaction controller between two requesters, such as a DMA engine and a CPU bridge. It grants one whole transaction at a time: address, all data beats, and, for writes, the response. Masters are served round-robin. The arbiter sits in the core_clk domain directly in front of the DDR controller's awaddr/wdata/araddr/rdata port.

## Interface
Parameters:
- ADDR_W, 26, byte address width (BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1)
- DATA_W, 16, data beat width (8<<DQ_LEVEL)

Ports:
- core_clk  input  1  sole clock; all logic on rising edge
- core_rst  input  1  reset, asynchronous, active-high
- mN_awvalid/mN_awready  in/out  1  write address handshake, N=0,1
- mN_awaddr  input  ADDR_W  write byte address
- mN_awlen  input  8  write beats minus 1
- mN_wvalid/mN_wready/mN_wlast  in/out/in  1  write data handshake
- mN_wdata  input  DATA_W  write beat
- mN_bvalid/mN_bready  out/in  1  write response
- mN_arvalid/mN_arready  in/out  1  read address handshake
- mN_araddr  input  ADDR_W; mN_arlen  input  8
- mN_rvalid/mN_rready/mN_rlast  out/in/out  1  read data handshake
- mN_rdata  output  DATA_W
- s_aw*/s_w*/s_b*/s_ar*/s_r*  mirrored directions and widths  single port to the DDR controller
- grant  output  2  one-hot owner of s_*; 00 when idle
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- Request of master N: req[N] = mN_awvalid | mN_arvalid. Requests are sampled only in IDLE.
- Round-robin arbitration uses the register last, the index of the most recently granted master (reset 1, so m0 wins first).
- If both masters request, grant goes to the master with index != last.
- If one master requests, it is granted.
- On grant, last is updated to the granted index.
- Within the granted master, a write is taken if mN_awvalid, else the read. Next state is WR_ADDR or RD_ADDR.
- Routing by state, for the granted master g; all other handshake outputs are 0:
  - WR_ADDR: s_awvalid = mg_awvalid; s_awaddr/s_awlen = mg's; mg_awready = s_awready. On handshake, capture len = mg_awlen, clear beat counter cnt, go to WR_DATA.
  - WR_DATA: s_wvalid/s_wdata/s_wlast from mg; mg_wready = s_wready. Each handshake increments cnt (8-bit). Phase ends on a beat with mg_wlast or cnt == len, then go to WR_RESP.
  - WR_RESP: mg_bvalid = s_bvalid; s_bready = mg_bready. On handshake go to IDLE.
  - RD_ADDR: s_arvalid/s_araddr/s_arlen from mg; mg_arready = s_arready. On handshake, capture len = mg_arlen, clear cnt, go to RD_DATA.
  - RD_DATA: mg_rvalid = s_rvalid; mg_rdata = s_rdata; mg_rlast = s_rlast | (cnt == len); s_rready = mg_rready. Phase ends on a beat with s_rlast or cnt == len, then go to IDLE.
- Datapath outputs while unowned: s_awaddr, s_wdata, s_araddr and both mN_rdata are driven 0.
- Reset, asynchronous, at any point including mid-burst:
  - state = IDLE, last = 1, cnt = 0, len = 0, grant = 00.
  - All valid/ready outputs 0.
  - An in-flight transaction is abandoned. The DDR controller is reset by the same event.

## Timing
- Arbitration latency: request present in IDLE at edge k gives state/grant updated at k+1. Forwarded valid is visible during cycle k+1.
- All handshake forwarding is combinational through muxes selected by registered state/grant. This adds no cycles per beat; one beat per cycle is sustained.
- Transaction end to next grant:
  - Final handshake at edge k puts the FSM in IDLE during cycle k+1.
  - A new grant is registered at edge k+2.
  - One idle bubble per transaction is the required behaviour.
- A master that drops awvalid/arvalid before its handshake in WR_ADDR/RD_ADDR is a protocol violation. The FSM holds its state; no timeout.
- Simultaneous aw and ar from the same master: the write is taken first. The read is served on that master's next grant.
- cnt wraps at 255; an awlen/arlen of 255 ends exactly at cnt == 255.

## Test plan
- Reset check -> grant=00, busy=0, all ready/valid outputs 0; m0 and m1 assert awvalid together -> grant=01 one cycle later.
- Contention round-robin:
  - Stimulus: m0 and m1 each issue back-to-back 4-beat writes (awlen=3).
  - Required: grants alternate 01,10,01,10; each gets exactly 4 s_w handshakes and 1 s_b handshake.
- Read path:
  - Stimulus: m1 arlen=7, s_rlast never asserted.
  - Required: m1_rlast high on the 8th beat; FSM back in IDLE after it; m0_rvalid stays 0 throughout.
- Early termination: write awlen=7 with mg_wlast on beat 3 -> WR_RESP entered after 3 beats.
- Backpressure:
  - Stimulus: s_wready and mg_rready toggled randomly.
  - Required: no beat lost or duplicated; data matches the source sequence.
- Async reset:
  - Stimulus: core_rst asserted mid-WR_DATA, between clock edges.
  - Required: outputs zero immediately; after release, m0 wins first under contention.
